// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared AES definitions: inverse S-box, GF(2^8) arithmetic, state byte helpers
// and the inverse-cipher FSM encoding.
package aes_inv_cipher_iter_pkg;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL
  } inv_state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // State byte (row r, column c) sits at bit [msb -: 8]; byte 0 is the MSB.
  function automatic int unsigned byte_msb(input int unsigned r, input int unsigned c);
    return 127 - 8 * (4 * c + r);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[byte_msb(r, c) -: 8] = s[byte_msb(r, (c + 4 - r) % 4) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = INV_SBOX[s[8*k +: 8]];
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_inv_mix_column.sv
// InvMixColumns on one 32-bit state column (top byte is row 0), combinational.
module inv_mix_column
  import aes_inv_cipher_iter_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign col_o = {
    gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
    gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
    gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
    gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
  };

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock with an external round-key store.
// Define AES_INV_PIPE_SBOX_EN to register InvShiftRows+InvSubBytes (two cycles per round).
module aes_inv_cipher_iter
  import aes_inv_cipher_iter_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ct_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] pt_out
);

  inv_state_e   state_q, state_d;
  logic [3:0]   r_q, r_d;
  logic [127:0] s_q, s_d;
  logic [127:0] pt_q, pt_d;
  logic         done_q, done_d;
  logic [127:0] sub_w, sb_w, ark_w, mix_w;
  logic         step_w;

  assign sub_w = inv_sub_bytes(inv_shift_rows(s_q));

`ifdef AES_INV_PIPE_SBOX_EN
  // Phase 0 captures the S-box result, phase 1 applies the key and advances.
  logic         ph_q;
  logic [127:0] t_q;

  always_ff @(posedge clk) begin
    if (rst) ph_q <= 1'b0;
    else     ph_q <= (state_q != ST_IDLE) ? ~ph_q : 1'b0;
  end

  always_ff @(posedge clk) t_q <= sub_w;

  assign sb_w   = t_q;
  assign step_w = ph_q;
`else
  assign sb_w   = sub_w;
  assign step_w = 1'b1;
`endif

  assign ark_w = sb_w ^ rk_in;

  for (genvar c = 0; c < 4; c++) begin : g_imc
    inv_mix_column u_imc (
      .col_i (ark_w[127-32*c -: 32]),
      .col_o (mix_w[127-32*c -: 32])
    );
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    s_d     = s_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    rk_idx  = 4'(NR);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d     = ct_in ^ rk_in;
          r_d     = 4'(NR - 1);
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        rk_idx = r_q;
        if (step_w) begin
          s_d = mix_w;
          r_d = r_q - 4'd1;
          if (r_q == 4'd1) state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        rk_idx = 4'd0;
        if (step_w) begin
          pt_d    = ark_w;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= 4'd0;
      done_q  <= 1'b0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      done_q  <= done_d;
      pt_q    <= pt_d;
    end
  end

  // Working state is meaningless outside a decryption, so it carries no reset.
  always_ff @(posedge clk) s_q <= s_d;

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign pt_out = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using FIPS-197 vectors; the round-key
// store is filled by a small AES-128 key expansion with an algorithmic S-box.
module tb_aes_inv_cipher_iter;

  localparam int NRV = 10;
`ifdef AES_INV_PIPE_SBOX_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  localparam int LAT = PIPE ? 2 * NRV : NRV;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst, start, busy, done, key_sel;
  logic [127:0] ct_in, rk_in, pt_out;
  logic [3:0]   rk_idx;
  logic [127:0] rk_a [16];
  logic [127:0] rk_b [16];
  logic [7:0]   sbox_m [256];
  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  assign rk_in = key_sel ? rk_b[rk_idx] : rk_a[rk_idx];

  aes_inv_cipher_iter #(.NR(NRV)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ct_in  (ct_in),
    .rk_idx (rk_idx),
    .rk_in  (rk_in),
    .busy   (busy),
    .done   (done),
    .pt_out (pt_out)
  );

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_m[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_m[0] = 8'h63;
  endtask

  task automatic expand_key(input logic [127:0] key, input bit which);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] rkv;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) begin
      rkv = '0;
      if (j <= NRV) rkv = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
      if (which) rk_b[j] = rkv;
      else       rk_a[j] = rkv;
    end
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_rk(input int j);
    return 4'(NRV - 1 - (PIPE ? j / 2 : j));
  endfunction

  // Call with start already driven high at a falling edge; returns at the done cycle.
  task automatic wait_done(input logic [127:0] hold, input int inj, input logic [127:0] inj_ct,
                           output int cyc, output bit rk_ok, output bit hold_ok);
    cyc = 0;
    rk_ok = 1'b1;
    hold_ok = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 4 * LAT) begin
      if (rk_idx !== exp_rk(cyc)) rk_ok = 1'b0;
      if (pt_out !== hold) hold_ok = 1'b0;
      if (cyc == inj) begin
        start = 1'b1;
        ct_in = inj_ct;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc, n;
    bit rk_ok, hold_ok;
    rst = 1'b1;
    start = 1'b0;
    ct_in = '0;
    key_sel = 1'b0;
    build_sbox();
    expand_key(KEY_A, 1'b0);
    expand_key(KEY_B, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_busy", 128'(busy), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    check("reset_pt", pt_out, 128'd0);
    check("idle_rk_idx", 128'(rk_idx), 128'(NRV));

    // C.1 vector from idle
    ct_in = CT_A;
    key_sel = 1'b0;
    start = 1'b1;
    wait_done(128'd0, -1, '0, cyc, rk_ok, hold_ok);
    check("c1_latency", 128'(cyc), 128'(LAT));
    check("c1_done", 128'(done), 128'd1);
    check("c1_pt", pt_out, PT_A);
    check("c1_rk_seq", 128'(rk_ok), 128'd1);
    check("c1_pt_hold", 128'(hold_ok), 128'd1);
    check("c1_busy_done", 128'(busy), 128'd0);
    check("c1_rk_idx_done", 128'(rk_idx), 128'(NRV));
    @(negedge clk);
    check("c1_done_pulse", 128'(done), 128'd0);
    check("c1_pt_after", pt_out, PT_A);

    // App.B vector
    key_sel = 1'b1;
    ct_in = CT_B;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b_busy", 128'(busy), 128'd1);
    start = 1'b1;
    wait_done(PT_A, -1, '0, cyc, rk_ok, hold_ok);
    check("b_latency", 128'(cyc), 128'(LAT - 1));
    check("b_pt", pt_out, PT_B);

    // start while busy is ignored
    key_sel = 1'b0;
    ct_in = CT_A;
    start = 1'b1;
    wait_done(PT_B, 4, CT_B, cyc, rk_ok, hold_ok);
    check("ign_latency", 128'(cyc), 128'(LAT));
    check("ign_pt", pt_out, PT_A);
    n = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (done) n++;
    end
    check("ign_extra_done", 128'(n), 128'd0);

    // Back-to-back: restart in the done cycle
    ct_in = CT_A;
    start = 1'b1;
    wait_done(PT_A, -1, '0, cyc, rk_ok, hold_ok);
    check("b2b_first_pt", pt_out, PT_A);
    key_sel = 1'b1;
    ct_in = CT_B;
    start = 1'b1;
    wait_done(PT_A, -1, '0, cyc, rk_ok, hold_ok);
    check("b2b_gap", 128'(cyc), 128'(LAT));
    check("b2b_second_pt", pt_out, PT_B);
    check("b2b_pt_hold", 128'(hold_ok), 128'd1);
    check("b2b_rk_seq", 128'(rk_ok), 128'd1);

    // Reset in the middle of a decryption
    @(negedge clk);
    key_sel = 1'b0;
    ct_in = CT_A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_done", 128'(done), 128'd0);
    check("abort_pt", pt_out, 128'd0);
    check("abort_rk_idx", 128'(rk_idx), 128'(NRV));
    n = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done) n++;
    end
    check("abort_no_done", 128'(n), 128'd0);

    // Fresh decryption after the abort
    ct_in = CT_A;
    start = 1'b1;
    wait_done(128'd0, -1, '0, cyc, rk_ok, hold_ok);
    check("fresh_latency", 128'(cyc), 128'(LAT));
    check("fresh_pt", pt_out, PT_A);
    check("fresh_rk_seq", 128'(rk_ok), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
